// File: rtl/vec_pkg.sv
// vec_pkg: shared position convention for the first-one detector and the vector builder.
package vec_pkg;
  localparam int DSIZE_DEF = 32;
  localparam int ASIZE_DEF = 6;
  localparam int EMPTY_POS = DSIZE_DEF;
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
endpackage

// File: rtl/vec_1_builder_if.sv
// vec_1_builder_if: position-in and vector-out valid/ready channels of the vector builder.
interface vec_1_builder_if #(
  parameter int DSIZE = vec_pkg::DSIZE_DEF,
  parameter int ASIZE = vec_pkg::ASIZE_DEF
);
  logic [ASIZE-1:0] pos_in;
  logic             pos_valid;
  logic             pos_last;
  logic             pos_ready;
  logic [DSIZE-1:0] vec_out;
  logic [ASIZE-1:0] vec_cnt;
  logic             vec_valid;
  logic             vec_ready;
  logic             vec_err;
  modport master (
    output pos_in, pos_valid, pos_last, vec_ready,
    input  pos_ready, vec_out, vec_cnt, vec_valid, vec_err
  );
  modport slave (
    input  pos_in, pos_valid, pos_last, vec_ready,
    output pos_ready, vec_out, vec_cnt, vec_valid, vec_err
  );
endinterface

// File: rtl/vec_pos_decoder.sv
// vec_pos_decoder: MSB-first position to one-hot; all-zero and out of range for pos >= DSIZE.
module vec_pos_decoder #(
  parameter int DSIZE = vec_pkg::DSIZE_DEF,
  parameter int ASIZE = vec_pkg::ASIZE_DEF
) (
  input  logic [ASIZE-1:0] pos_i,
  output logic [DSIZE-1:0] onehot_o,
  output logic             in_range_o
);
  assign in_range_o = pos_i < ASIZE'(DSIZE);
  assign onehot_o   = in_range_o ? {1'b1, {(DSIZE-1){1'b0}}} >> pos_i : '0;
endmodule

// File: rtl/vec_1_builder.sv
// vec_1_builder: ORs a stream of MSB-first bit positions into a vector, one frame per last beat.
// Define VEC_1_BUILDER_DUP_CHECK_EN to also flag repeated positions in a frame as errors.
module vec_1_builder import vec_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input logic            clk,
  input logic            rst_n,
  vec_1_builder_if.slave bus
);
  state_t           state_q;
  logic [DSIZE-1:0] acc_q, acc_d, vec_q, onehot;
  logic [ASIZE-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, valid_q, ready_q, in_range, dup, take;
  vec_pos_decoder #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_dec (
    .pos_i      (bus.pos_in),
    .onehot_o   (onehot),
    .in_range_o (in_range)
  );
`ifdef VEC_1_BUILDER_DUP_CHECK_EN
  assign dup = |(acc_q & onehot);
`else
  assign dup = 1'b0;
`endif
  // The empty marker is out of range for the decoder but is not an error.
  always_comb begin
    take  = bus.pos_valid & ready_q;
    acc_d = acc_q | onehot;
    cnt_d = cnt_q + ASIZE'(cnt_q != '1);
    err_d = err_q | dup | (!in_range && bus.pos_in != ASIZE'(DSIZE));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (state_q == OUT) begin
      if (bus.vec_ready) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        err_q   <= 1'b0;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end
    end else if (take) begin
      state_q <= bus.pos_last ? OUT : ACCUM;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= bus.pos_last;
      ready_q <= !bus.pos_last;
      if (bus.pos_last) vec_q <= acc_d;
    end
  end
  assign bus.vec_out   = vec_q;
  assign bus.vec_cnt   = cnt_q;
  assign bus.vec_err   = err_q;
  assign bus.vec_valid = valid_q;
  assign bus.pos_ready = ready_q;
endmodule
